ftm_buffer_writer: RTL and testbench
====================================

// Module: ftm_buffer_writer
// PURPOSE
//   Write side of the feature-map bank buffers. Accepts a 64-bit beat stream of one
//   feature map from the DDR read path and scatters it into N_BUF_X column-interleaved
//   banks, using the layout the buffer read path addresses:
//   bank = x mod N_BUF_X, addr = n_wrap_c*(y + h*floor(x/N_BUF_X)) + cw.
// PARAMETERS
//   N_BUF_X     5   number of banks; column x goes to bank x mod N_BUF_X (max 16)
//   B_BUF_ADDR  9   per-bank address width
//   B_SHAPE     32  shape word width
//   B_COORD     10  x/y counter width
//   DATA_WIDTH  64  beat width, equal to one 64-channel word
// PORTS
//   clk        in   1                      clock
//   rstn       in   1                      synchronous reset, active-low
//   ftm_shape  in   B_SHAPE                {c[31:20], h[19:10], w[9:0]}; sampled on accepted start
//   start      in   1                      pulse; begin one feature-map transfer
//   busy       out  1                      high from accepted start until done
//   done       out  1                      1-cycle pulse after the last bank write
//   s_data     in   DATA_WIDTH             input beat
//   s_valid    in   1                      beat valid
//   s_ready    out  1                      beat accepted when s_valid & s_ready
//   wraddr     out  B_BUF_ADDR*N_BUF_X     per-bank write address; slice i for bank i
//   wrdata     out  DATA_WIDTH             write data, broadcast to all banks
//   wren       out  N_BUF_X                one-hot bank write enable
//   wr_sel     out  4                      index of bank written this cycle (rx)
// BEHAVIOUR
//   - Reset: state=IDLE; busy, done, s_ready, wren = 0; wraddr, wrdata, wr_sel = 0; all counters 0.
//   - Shape decode: n_wrap_c = c>>6 (8b), h = [19:10], w = [9:0]; latched on start.
//   - Beat order: x outer, y middle, cw inner (cw = 0..n_wrap_c-1). Total beats = w*h*n_wrap_c.
//   - FSM:
//     IDLE  --start-------------------------------> WRITE (busy=1); if n_wrap_c, h or w == 0 -> DONE
//     WRITE --accept of last beat (x=w-1, y=h-1, cw=n_wrap_c-1)--> FLUSH
//     FLUSH --1 cycle; last write is on the bank port--> DONE
//     DONE  --done=1 for 1 cycle, busy=0----------> IDLE
//   - start is ignored outside IDLE.
//   - s_ready = (state==WRITE). There is no combinational path from s_valid to s_ready.
//   - Latency 1: a beat accepted in cycle t gives wren one-hot at bit rx, wraddr slice rx = addr,
//     and wrdata = beat in cycle t+1. All other wraddr slices = 0. wren = 0 on cycles with no accept.
//   - Address generation has no multiplier. Registers: addr_r, col_base_r, rx_r, qx_r.
//     The address is generated by these rules:
//     * each accept: addr_r += 1 (mod 2^B_BUF_ADDR); cw, y and x advance in beat order.
//     * end of column (y=h-1, cw=n_wrap_c-1):
//       - rx_r == N_BUF_X-1: rx_r <= 0, qx_r += 1, col_base_r <= addr_r+1, addr_r <= addr_r+1.
//       - otherwise: rx_r += 1, addr_r <= col_base_r.
//     * Result: bank k's region for qx starts at n_wrap_c*h*qx.
//   - Address overflow wraps modulo 2^B_BUF_ADDR with no flag; sizing the shape to fit is the caller's job.
//   - s_valid gaps stall all counters; no beats are dropped or duplicated.
//   - If rstn falls mid-transfer, the next cycle shows reset values and the partial map is abandoned.
//     done is not pulsed.
// TESTING
//   1. N=5, shape c=128,h=2,w=7 (n_wrap_c=2), 28 beats data=0..27 -> bank0 addr0-3=d0-3;
//      bank4 addr0-3=d16-19; bank0 addr4-7=d20-23; bank1 addr4-7=d24-27; done 2 cycles after beat 27.
//   2. Same shape, s_valid toggling 1/0 each cycle -> identical bank contents; wren only on cycles after accepts.
//   3. shape c=32 (n_wrap_c=0) or w=0 -> no wren, busy 1 cycle, done pulse, s_ready never high.
//   4. start re-pulsed mid-transfer with a different shape -> ignored; original 28-beat layout is written.
//   5. rstn low after beat 10 of test 1 -> next cycle busy=0, s_ready=0, wren=0, no done;
//      a new start then writes from bank0 addr0.
//   6. w=1, h=1, c=64 -> single beat: bank0 addr0, done pulse; back-to-back start is accepted in IDLE.

Source files
------------

// File: rtl/ftm_buffer_writer.sv
// Feature-map buffer write side: scatters a 64-bit beat stream into N_BUF_X column-interleaved
// banks, bank = x mod N_BUF_X, addr = n_wrap_c*(y + h*floor(x/N_BUF_X)) + cw.
module ftm_buffer_writer #(
    parameter int unsigned N_BUF_X    = 5,
    parameter int unsigned B_BUF_ADDR = 9,
    parameter int unsigned B_SHAPE    = 32,
    parameter int unsigned B_COORD    = 10,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [B_SHAPE-1:0]             ftm_shape,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [B_BUF_ADDR*N_BUF_X-1:0]  wraddr,
    output logic [DATA_WIDTH-1:0]          wrdata,
    output logic [N_BUF_X-1:0]             wren,
    output logic [3:0]                     wr_sel
);

    localparam int unsigned WaW = B_BUF_ADDR * N_BUF_X;

    typedef enum logic [1:0] {StIdle, StWrite, StFlush, StDone} state_e;

    state_e                 state_q;
    logic [7:0]             nwc_q, cw_q;
    logic [B_COORD-1:0]     h_q, w_q, y_q, x_q, qx_q;
    logic [B_BUF_ADDR-1:0]  addr_q, col_base_q;
    logic [3:0]             rx_q;

    logic                   busy_q, done_q, s_ready_q;
    logic [WaW-1:0]         wraddr_q;
    logic [DATA_WIDTH-1:0]  wrdata_q;
    logic [N_BUF_X-1:0]     wren_q;
    logic [3:0]             wr_sel_q;

    logic [7:0]             in_nwc;
    logic [B_COORD-1:0]     in_h, in_w;
    logic                   zero_shape, accept, last_cw, last_y, last_x, col_end, rx_last;

    assign in_nwc     = {2'b00, ftm_shape[31:26]};
    assign in_h       = B_COORD'(ftm_shape[19:10]);
    assign in_w       = B_COORD'(ftm_shape[9:0]);
    assign zero_shape = (in_nwc == 8'd0) || (in_h == '0) || (in_w == '0);

    assign accept  = s_ready_q & s_valid;
    assign last_cw = (cw_q == nwc_q - 8'd1);
    assign last_y  = (y_q == h_q - B_COORD'(1));
    assign last_x  = (x_q == w_q - B_COORD'(1));
    assign col_end = last_cw & last_y;
    assign rx_last = (rx_q == 4'(N_BUF_X - 1));

    // qx is kept for debug visibility; the address itself is built incrementally.
    logic unused_bits;
    assign unused_bits = ^{ftm_shape[25:20], qx_q};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            nwc_q      <= '0;
            cw_q       <= '0;
            h_q        <= '0;
            w_q        <= '0;
            y_q        <= '0;
            x_q        <= '0;
            qx_q       <= '0;
            addr_q     <= '0;
            col_base_q <= '0;
            rx_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s_ready_q  <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            wren_q     <= '0;
            wr_sel_q   <= '0;
        end else begin
            wren_q   <= '0;
            wraddr_q <= '0;
            done_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        nwc_q      <= in_nwc;
                        h_q        <= in_h;
                        w_q        <= in_w;
                        cw_q       <= '0;
                        y_q        <= '0;
                        x_q        <= '0;
                        qx_q       <= '0;
                        addr_q     <= '0;
                        col_base_q <= '0;
                        rx_q       <= '0;
                        busy_q     <= 1'b1;
                        // Empty maps spend their single busy cycle in FLUSH with no write.
                        if (zero_shape) begin
                            state_q <= StFlush;
                        end else begin
                            state_q   <= StWrite;
                            s_ready_q <= 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (accept) begin
                        wren_q   <= N_BUF_X'(1) << rx_q;
                        wraddr_q <= WaW'(addr_q) << (B_BUF_ADDR * rx_q);
                        wrdata_q <= s_data;
                        wr_sel_q <= rx_q;
                        cw_q     <= last_cw ? 8'd0 : cw_q + 8'd1;
                        if (last_cw) y_q <= last_y ? '0 : y_q + B_COORD'(1);
                        if (col_end) begin
                            x_q <= x_q + B_COORD'(1);
                            if (rx_last) begin
                                rx_q       <= '0;
                                qx_q       <= qx_q + B_COORD'(1);
                                col_base_q <= addr_q + B_BUF_ADDR'(1);
                                addr_q     <= addr_q + B_BUF_ADDR'(1);
                            end else begin
                                rx_q   <= rx_q + 4'd1;
                                addr_q <= col_base_q;
                            end
                        end else begin
                            addr_q <= addr_q + B_BUF_ADDR'(1);
                        end
                        if (col_end && last_x) begin
                            state_q   <= StFlush;
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                StFlush: begin
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign s_ready = s_ready_q;
    assign wraddr  = wraddr_q;
    assign wrdata  = wrdata_q;
    assign wren    = wren_q;
    assign wr_sel  = wr_sel_q;

endmodule

// File: tb/tb_ftm_buffer_writer.sv
// Directed bench for ftm_buffer_writer: captures bank writes into a memory image and checks
// it against the closed-form layout, plus handshake/done/reset timing.
module tb_ftm_buffer_writer;

    localparam int N  = 5;
    localparam int BA = 9;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic [31:0]     ftm_shape;
    logic            start;
    logic            busy, done;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic [BA*N-1:0] wraddr;
    logic [DW-1:0]   wrdata;
    logic [N-1:0]    wren;
    logic [3:0]      wr_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    bit mon_en  = 1'b0;
    logic acc_pend = 1'b0;
    logic [DW-1:0] mem [0:N-1][0:511];

    always #5 clk = ~clk;

    ftm_buffer_writer dut (
        .clk(clk), .rstn(rstn), .ftm_shape(ftm_shape), .start(start), .busy(busy),
        .done(done), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wraddr(wraddr), .wrdata(wrdata), .wren(wren), .wr_sel(wr_sel)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] shp(input int c, input int h, input int w);
        logic [11:0] cc;
        logic [9:0]  hh, ww;
        cc = 12'(c);
        hh = 10'(h);
        ww = 10'(w);
        return {cc, hh, ww};
    endfunction

    // Write monitor: wren must follow exactly one cycle after each accept.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("wren_after_accept", 64'(|wren), 64'(acc_pend));
            if (wren != '0) begin
                chk("wren_onehot", 64'($onehot(wren)), 64'd1);
                for (int b = 0; b < N; b++) begin
                    if (wren[b]) begin
                        mem[b][wraddr[b*BA +: BA]] = wrdata;
                        n_wr++;
                        chk("wr_sel", 64'(wr_sel), 64'(b));
                    end else begin
                        chk("wraddr_idle_slice", 64'(wraddr[b*BA +: BA]), 64'd0);
                    end
                end
            end
            acc_pend = s_valid & s_ready & rstn;
        end
    end

    task automatic clear_mem();
        for (int b = 0; b < N; b++)
            for (int a = 0; a < 512; a++) mem[b][a] = 'x;
        n_wr = 0;
    endtask

    task automatic pulse_start(input logic [31:0] s);
        ftm_shape = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beats(input int first, input int cnt, input int base, input bit toggle);
        for (int k = 0; k < cnt; k++) begin
            int guard;
            logic acc;
            guard = 0;
            s_data  = 64'(base + first + k);
            s_valid = 1'b1;
            forever begin
                acc = s_ready;
                @(posedge clk); #1;
                if (acc) break;
                guard++;
                if (guard > 100) begin
                    chk("beat_timeout", 64'd0, 64'd1);
                    s_valid = 1'b0;
                    return;
                end
            end
            if (toggle) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        @(negedge clk);
        while (done !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_low_at_done", 64'(busy), 64'd0);
    endtask

    task automatic check_layout(input int nwc, input int h, input int w, input int base);
        for (int i = 0; i < nwc * h * w; i++) begin
            int x, y, cw, bank, addr;
            x    = i / (h * nwc);
            y    = (i / nwc) % h;
            cw   = i % nwc;
            bank = x % N;
            addr = nwc * (y + h * (x / N)) + cw;
            chk("layout", mem[bank][addr % 512], 64'(base + i));
        end
        chk("write_count", 64'(n_wr), 64'(nwc * h * w));
    endtask

    task automatic run_zero(input logic [31:0] s, input string tag);
        int nb, nd, nr;
        nb = 0; nd = 0; nr = 0;
        clear_mem();
        pulse_start(s);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nb += int'(busy);
            nd += int'(done);
            nr += int'(s_ready);
        end
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd1);
        chk({tag, "_done_pulses"}, 64'(nd), 64'd1);
        chk({tag, "_sready_cycles"}, 64'(nr), 64'd0);
        chk({tag, "_writes"}, 64'(n_wr), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; ftm_shape = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd0);
        chk("rst_wren", 64'(wren), 64'd0);
        chk("rst_wraddr", 64'(wraddr), 64'd0);
        chk("rst_wrdata", wrdata, 64'd0);
        chk("rst_wr_sel", 64'(wr_sel), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        mon_en = 1'b1;

        // 1: c=128 h=2 w=7, continuous beats
        pulse_start(shp(128, 2, 7));
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_sready", 64'(s_ready), 64'd1);
        send_beats(0, 28, 0, 1'b0);
        @(negedge clk);
        chk("t1_last_wren", 64'(wren), 64'b00010);
        chk("t1_last_addr", 64'(wraddr[1*BA +: BA]), 64'd7);
        chk("t1_last_done", 64'(done), 64'd0);
        chk("t1_flush_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_done_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);
        for (int a = 0; a < 4; a++) begin
            chk("t1_b0_lo", mem[0][a], 64'(a));
            chk("t1_b4_lo", mem[4][a], 64'(16 + a));
            chk("t1_b0_hi", mem[0][4 + a], 64'(20 + a));
            chk("t1_b1_hi", mem[1][4 + a], 64'(24 + a));
        end
        check_layout(2, 2, 7, 0);

        // 2: same shape, s_valid toggling
        @(posedge clk); #1;
        clear_mem();
        pulse_start(shp(128, 2, 7));
        send_beats(0, 28, 200, 1'b1);
        wait_done();
        check_layout(2, 2, 7, 200);

        // 3: empty shapes
        @(posedge clk); #1;
        run_zero(shp(32, 2, 7), "t3_c32");
        run_zero(shp(128, 2, 0), "t3_w0");

        // 4: start re-pulsed mid-transfer is ignored
        clear_mem();
        pulse_start(shp(128, 2, 7));
        send_beats(0, 10, 300, 1'b0);
        pulse_start(shp(64, 1, 1));
        chk("t4_busy", 64'(busy), 64'd1);
        send_beats(10, 18, 300, 1'b0);
        wait_done();
        check_layout(2, 2, 7, 300);

        // 5: reset after beat 10
        @(posedge clk); #1;
        clear_mem();
        pulse_start(shp(128, 2, 7));
        send_beats(0, 11, 400, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_sready", 64'(s_ready), 64'd0);
        chk("t5_wren", 64'(wren), 64'd0);
        chk("t5_done", 64'(done), 64'd0);
        rstn = 1'b1;
        begin
            int nd;
            nd = 0;
            repeat (4) begin
                @(negedge clk);
                nd += int'(done);
            end
            chk("t5_no_done", 64'(nd), 64'd0);
        end
        @(posedge clk); #1;
        clear_mem();
        pulse_start(shp(128, 2, 7));
        send_beats(0, 28, 100, 1'b0);
        wait_done();
        chk("t5_restart_b0a0", mem[0][0], 64'd100);
        check_layout(2, 2, 7, 100);

        // 6: single beat, then back-to-back start
        @(posedge clk); #1;
        clear_mem();
        pulse_start(shp(64, 1, 1));
        send_beats(0, 1, 50, 1'b0);
        wait_done();
        chk("t6_b0a0", mem[0][0], 64'd50);
        chk("t6_writes", 64'(n_wr), 64'd1);
        @(posedge clk); #1;
        pulse_start(shp(64, 1, 1));
        chk("t6_b2b_busy", 64'(busy), 64'd1);
        chk("t6_b2b_sready", 64'(s_ready), 64'd1);
        send_beats(0, 1, 55, 1'b0);
        wait_done();
        chk("t6_b2b_b0a0", mem[0][0], 64'd55);

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
